// File: rtl/ours_vld_rdy_dst_demux_buf_pkg.sv
// Shared constants and helpers for the destination demux buffer.
// Holds the drop-counter width and its saturating increment so the top
// module and any future siblings agree on the counter behaviour.
package ours_vld_rdy_dst_demux_buf_pkg;

    localparam int DROP_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ours_vld_rdy_fifo_lite.sv
// Small valid/ready FIFO used as one per-destination output buffer.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   push_valid/ready    write side handshake, push_data payload
//   pop_valid/ready     read side handshake, pop_data is the head entry
//   not_empty           high while at least one entry is stored
// DEPTH==0 turns the block into a combinational wire-through.
module ours_vld_rdy_fifo_lite
    import ours_vld_rdy_dst_demux_buf_pkg::*;
#(
    parameter int BACKEND_DOMAIN = 0,
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_empty
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign pop_valid  = push_valid;
            assign push_ready = pop_ready;
            assign pop_data   = push_data;
            // Nothing is ever held, so the buffer never counts as occupied.
            assign not_empty  = 1'b0;
        end else begin : g_buf
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam int CNT_W = $clog2(DEPTH + 1);
            localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
            localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [WIDTH-1:0] mem_d [DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] count_q, count_d;
            logic             push, pop;

            // Explicit wrap keeps non-power-of-2 depths correct.
            function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
                return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
            endfunction

            // Ready depends only on occupancy: a pop this cycle frees the
            // slot for the next cycle, never the current one.
            assign push_ready = (count_q != FULL_CNT);
            assign pop_valid  = (count_q != '0);
            assign not_empty  = pop_valid;
            assign pop_data   = mem_q[rd_ptr_q];
            assign push       = push_valid & push_ready;
            assign pop        = pop_valid & pop_ready;

            always_comb begin
                mem_d    = mem_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push) begin
                    mem_d[wr_ptr_q] = push_data;
                    wr_ptr_d        = next_ptr(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_d = next_ptr(rd_ptr_q);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Payload storage carries no reset; validity comes from count_q.
            always_ff @(posedge clk) begin
                mem_q <= mem_d;
            end
        end
    endgenerate

endmodule

// File: rtl/ours_vld_rdy_dst_demux_buf.sv
// Steers one valid/ready input stream to N_OUTPUT valid/ready outputs
// selected per beat by slave_dst, with a FIFO per output so a stalled
// destination only blocks the input while a beat targets it.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   slave_valid/ready, slave_dst/info input beat and its destination
//   master_valid/ready[N_OUTPUT]      per-destination handshake
//   master_info[N_OUTPUT*WIDTH]       per-destination payload, lane k at k*WIDTH
//   drop_pulse, drop_cnt              out-of-range beat drop reporting
//   clk_en                            enable request for the upstream ICG
module ours_vld_rdy_dst_demux_buf
    import ours_vld_rdy_dst_demux_buf_pkg::*;
#(
    parameter int BACKEND_DOMAIN = 0,
    parameter int N_OUTPUT       = 8,
    parameter int WIDTH          = 32,
    parameter int DST_WIDTH      = $clog2(N_OUTPUT),
    parameter int BUF_OUT_DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      slave_valid,
    input  logic [DST_WIDTH-1:0]      slave_dst,
    input  logic [WIDTH-1:0]          slave_info,
    output logic                      slave_ready,
    output logic [N_OUTPUT-1:0]       master_valid,
    output logic [N_OUTPUT*WIDTH-1:0] master_info,
    input  logic [N_OUTPUT-1:0]       master_ready,
    output logic                      drop_pulse,
    output logic [DROP_CNT_W-1:0]     drop_cnt,
    output logic                      clk_en
);

    logic [N_OUTPUT-1:0]   push_valid;
    logic [N_OUTPUT-1:0]   push_ready;
    logic [N_OUTPUT-1:0]   not_empty;
    logic                  in_range;
    logic                  dst_ready;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // With a power-of-2 output count every index is legal, and the compare
    // would be constant.
    generate
        if ((1 << DST_WIDTH) == N_OUTPUT) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (slave_dst < DST_WIDTH'(N_OUTPUT));
        end
    endgenerate

    // Decode destination; an index matching no output leaves dst_ready at 1
    // so out-of-range beats are swallowed.
    always_comb begin
        push_valid = '0;
        dst_ready  = 1'b1;
        for (int k = 0; k < N_OUTPUT; k++) begin
            if (slave_dst == DST_WIDTH'(k)) begin
                push_valid[k] = slave_valid;
                dst_ready     = push_ready[k];
            end
        end
    end

    assign slave_ready = dst_ready;

    generate
        for (genvar g = 0; g < N_OUTPUT; g++) begin : g_out
            ours_vld_rdy_fifo_lite #(
                .BACKEND_DOMAIN (BACKEND_DOMAIN),
                .WIDTH          (WIDTH),
                .DEPTH          (BUF_OUT_DEPTH)
            ) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .push_valid (push_valid[g]),
                .push_ready (push_ready[g]),
                .push_data  (slave_info),
                .pop_valid  (master_valid[g]),
                .pop_ready  (master_ready[g]),
                .pop_data   (master_info[g*WIDTH +: WIDTH]),
                .not_empty  (not_empty[g])
            );
        end
    endgenerate

    always_comb begin
        drop_pulse_d = slave_valid & ~in_range;
        drop_cnt_d   = drop_pulse_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;
    assign clk_en     = rst | slave_valid | (|not_empty) | drop_pulse_q;

endmodule

// File: tb/tb_ours_vld_rdy_dst_demux_buf.sv
module tb_ours_vld_rdy_dst_demux_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 5 outputs (non-power-of-2), depth 2
    logic         a_valid = 1'b0;
    logic [2:0]   a_dst = '0;
    logic [31:0]  a_info = '0;
    logic         a_ready;
    logic [4:0]   a_mvalid;
    logic [159:0] a_minfo;
    logic [4:0]   a_mready = '1;
    logic         a_drop_pulse;
    logic [15:0]  a_drop_cnt;
    logic         a_clk_en;

    // Instance Z: 4 outputs, depth 0 (pass-through)
    logic         z_valid = 1'b0;
    logic [1:0]   z_dst = '0;
    logic [31:0]  z_info = '0;
    logic         z_ready;
    logic [3:0]   z_mvalid;
    logic [127:0] z_minfo;
    logic [3:0]   z_mready = '1;
    logic         z_drop_pulse;
    logic [15:0]  z_drop_cnt;
    logic         z_clk_en;

    ours_vld_rdy_dst_demux_buf #(.N_OUTPUT(5), .WIDTH(32), .BUF_OUT_DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .slave_valid(a_valid), .slave_dst(a_dst), .slave_info(a_info), .slave_ready(a_ready),
        .master_valid(a_mvalid), .master_info(a_minfo), .master_ready(a_mready),
        .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt), .clk_en(a_clk_en)
    );

    ours_vld_rdy_dst_demux_buf #(.N_OUTPUT(4), .WIDTH(32), .BUF_OUT_DEPTH(0)) u_dut_z (
        .clk(clk), .rst(rst),
        .slave_valid(z_valid), .slave_dst(z_dst), .slave_info(z_info), .slave_ready(z_ready),
        .master_valid(z_mvalid), .master_info(z_minfo), .master_ready(z_mready),
        .drop_pulse(z_drop_pulse), .drop_cnt(z_drop_cnt), .clk_en(z_clk_en)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model for A: one bounded queue per destination.
    logic [31:0] qa [5][$];
    int          mdrop  = 0;
    bit          mpulse = 1'b0;
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive, check against model, advance one cycle.
    task automatic step_a(input bit v, input int dst, input logic [31:0] info, input logic [4:0] mr);
        bit er;
        bit anyq;
        a_valid  = v;
        a_dst    = 3'(dst);
        a_info   = info;
        a_mready = mr;
        #1;
        er = 1'b1;
        if (dst < 5) er = (qa[dst].size() < 2);
        anyq = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("a_mvalid%0d", k), 32'(a_mvalid[k]), 32'(qa[k].size() > 0));
            if (qa[k].size() > 0) begin
                anyq = 1'b1;
                chk($sformatf("a_minfo%0d", k), a_minfo[k*32 +: 32], qa[k][0]);
            end
        end
        chk("a_slave_ready", 32'(a_ready), 32'(er));
        chk("a_drop_pulse", 32'(a_drop_pulse), 32'(mpulse));
        chk("a_drop_cnt", 32'(a_drop_cnt), 32'(mdrop));
        chk("a_clk_en", 32'(a_clk_en), 32'(v | anyq | mpulse));
        last_acc = v && er;
        @(posedge clk);
        for (int k = 0; k < 5; k++)
            if (mr[k] && qa[k].size() > 0) void'(qa[k].pop_front());
        if (last_acc && dst < 5) qa[dst].push_back(info);
        mpulse = last_acc && (dst >= 5);
        if (mpulse && mdrop < 65535) mdrop++;
        @(negedge clk);
    endtask

    // Present a beat until accepted, bounded.
    task automatic beat_a(input int dst, input logic [31:0] info, input logic [4:0] mr);
        int n = 0;
        do begin
            step_a(1'b1, dst, info, mr);
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) begin
            n_chk++;
            n_fail++;
            $error("FAIL a_accept_timeout: observed stalled expected accepted dst %0d", dst);
        end
    endtask

    initial begin
        int zcnt_m [4];
        int zcnt_d [4];

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mvalid", 32'(a_mvalid), 32'(0));
        chk("rst_drop_cnt", 32'(a_drop_cnt), 32'(0));
        chk("rst_drop_pulse", 32'(a_drop_pulse), 32'(0));
        chk("rst_clk_en", 32'(a_clk_en), 32'(1));
        @(negedge clk);
        rst = 1'b0;

        // Plan 1: one beat per destination, latency 1
        for (int k = 0; k < 4; k++) step_a(1'b1, k, 32'hA0 + k, 5'h1f);
        for (int k = 0; k < 3; k++) step_a(1'b0, 0, 32'h0, 5'h1f);

        // Plan 2/3: stalled dst 2, head-of-line block, pop frees slot next cycle
        beat_a(2, 32'hB0, 5'b11011);
        beat_a(2, 32'hB1, 5'b11011);
        step_a(1'b1, 2, 32'hB2, 5'b11011);
        chk("t2_blocked", 32'(last_acc), 32'(0));
        step_a(1'b1, 2, 32'hB2, 5'b11111);
        chk("t3_pop_same_cycle", 32'(last_acc), 32'(0));
        step_a(1'b1, 2, 32'hB2, 5'b11111);
        chk("t3_next_cycle", 32'(last_acc), 32'(1));
        beat_a(1, 32'hB3, 5'b11111);
        for (int k = 0; k < 4; k++) step_a(1'b0, 0, 32'h0, 5'h1f);

        // Plan 4: out-of-range drops and saturation
        step_a(1'b1, 6, 32'hDEAD, 5'h1f);
        step_a(1'b0, 6, 32'h0, 5'h1f);
        step_a(1'b0, 6, 32'h0, 5'h1f);
        a_valid = 1'b1;
        a_dst   = 3'd7;
        repeat (66000) @(negedge clk);
        mdrop  = 65535;
        mpulse = 1'b1;
        step_a(1'b1, 5, 32'h0, 5'h1f);
        step_a(1'b0, 0, 32'h0, 5'h1f);

        // Plan 5: fill every FIFO, then async reset between edges
        for (int k = 0; k < 5; k++) begin
            beat_a(k, 32'hC0 + 2 * k, 5'h00);
            beat_a(k, 32'hC1 + 2 * k, 5'h00);
        end
        step_a(1'b0, 0, 32'h0, 5'h00);
        a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_mvalid", 32'(a_mvalid), 32'(0));
        chk("mid_rst_drop_cnt", 32'(a_drop_cnt), 32'(0));
        chk("mid_rst_clk_en", 32'(a_clk_en), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) qa[k].delete();
        mdrop  = 0;
        mpulse = 1'b0;
        step_a(1'b0, 0, 32'h0, 5'h1f);

        // Random traffic on A against the queue model
        for (int i = 0; i < 1500; i++)
            step_a($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom, 5'($urandom_range(0, 31)));
        for (int i = 0; i < 6; i++) step_a(1'b0, 0, 32'h0, 5'h1f);

        // Plan 6: depth 0, random traffic and ready
        for (int k = 0; k < 4; k++) begin
            zcnt_m[k] = 0;
            zcnt_d[k] = 0;
        end
        for (int i = 0; i < 500; i++) begin
            z_valid  = ($urandom_range(0, 3) != 0);
            z_dst    = 2'($urandom_range(0, 3));
            z_info   = $urandom;
            z_mready = 4'($urandom_range(0, 15));
            #1;
            chk("z_slave_ready", 32'(z_ready), 32'(z_mready[z_dst]));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("z_mvalid%0d", k), 32'(z_mvalid[k]), 32'(z_valid && (z_dst == 2'(k))));
                if (z_valid && z_dst == 2'(k)) chk($sformatf("z_minfo%0d", k), z_minfo[k*32 +: 32], z_info);
                if (z_mvalid[k] && z_mready[k]) zcnt_d[k]++;
            end
            if (z_valid && z_mready[z_dst]) zcnt_m[z_dst]++;
            chk("z_clk_en", 32'(z_clk_en), 32'(z_valid));
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("z_xfer_cnt%0d", k), 32'(zcnt_d[k]), 32'(zcnt_m[k]));
        chk("z_drop_cnt", 32'(z_drop_cnt), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
